// File: rtl/ps_fetch_seq.sv
// rtl/ps_fetch_seq.sv - program-sequencer fetch address generator with PC stack and DO-UNTIL loop stack
module ps_fetch_seq #(
    parameter int              AW          = 16,
    parameter int              PCSTK_DEPTH = 4,
    parameter int              LOOP_DEPTH  = 2,
    parameter int              CW          = 16,
    parameter logic [AW-1:0]   RST_VEC     = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         jmp,
    input  logic [AW-1:0]                jmp_addr,
    input  logic                         call,
    input  logic [AW-1:0]                ret_addr,
    input  logic                         ret,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                push_data,
    input  logic                         do_en,
    input  logic [AW-1:0]                do_start,
    input  logic [AW-1:0]                do_end,
    input  logic [CW-1:0]                do_cnt,
    input  logic                         clr_stcky,
    output logic [AW-1:0]                faddr,
    output logic [AW-1:0]                stk_top,
    output logic [$clog2(PCSTK_DEPTH):0] stk_ptr,
    output logic [4:0]                   stcky,
    output logic                         lp_active,
    output logic [CW-1:0]                lp_cnt
);
    localparam int PW  = $clog2(PCSTK_DEPTH) + 1;
    localparam int PIW = PW - 1;
    localparam int LW  = $clog2(LOOP_DEPTH) + 1;
    localparam int LIW = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    logic [AW-1:0]  r_faddr;
    logic [AW-1:0]  r_pcstk [PCSTK_DEPTH];
    logic [PW-1:0]  r_ptr;
    logic           r_povf, r_pudf, r_lovf;
    logic [AW-1:0]  r_ls_start [LOOP_DEPTH];
    logic [AW-1:0]  r_ls_end   [LOOP_DEPTH];
    logic [CW-1:0]  r_ls_cnt   [LOOP_DEPTH];
    logic [LW-1:0]  r_lptr;

    logic           w_pc_empty, w_pc_full, w_redir, w_push, w_pop;
    logic [PIW-1:0] w_top_idx;
    logic [AW-1:0]  w_pc_top, w_pdata, w_faddr_nxt;
    logic           w_lp_active, w_lp_full, w_lp_hit, w_lp_back, w_lp_exit, w_do;
    logic           w_set_povf, w_set_pudf, w_set_lovf;
    logic [LIW-1:0] w_ltop_idx;
    logic [AW-1:0]  w_lp_start, w_lp_end;
    logic [CW-1:0]  w_lp_cnt, w_do_cnt;

    assign w_pc_empty = (r_ptr == '0);
    assign w_pc_full  = (r_ptr == PW'(PCSTK_DEPTH));
    // Low index bits wrap correctly even when the pointer equals the depth.
    assign w_top_idx  = r_ptr[PIW-1:0] - PIW'(1);
    assign w_pc_top   = w_pc_empty ? '0 : r_pcstk[w_top_idx];

    assign w_redir    = jmp | call | ret;
    assign w_push     = call | (push & ~w_redir);
    assign w_pop      = (ret & ~jmp & ~call) | (pop & ~w_redir);
    assign w_pdata    = call ? ret_addr : push_data;
    assign w_set_povf = w_push & ~w_pop & w_pc_full;
    assign w_set_pudf = w_pop & ~w_push & w_pc_empty;

    assign w_lp_active = (r_lptr != '0);
    assign w_lp_full   = (r_lptr == LW'(LOOP_DEPTH));
    assign w_ltop_idx  = r_lptr[LIW-1:0] - LIW'(1);
    assign w_lp_start  = r_ls_start[w_ltop_idx];
    assign w_lp_end    = r_ls_end[w_ltop_idx];
    assign w_lp_cnt    = w_lp_active ? r_ls_cnt[w_ltop_idx] : '0;
    assign w_lp_hit    = w_lp_active & ~stall & ~w_redir & (r_faddr == w_lp_end);
    assign w_lp_back   = w_lp_hit & (w_lp_cnt > CW'(1));
    assign w_lp_exit   = w_lp_hit & ~(w_lp_cnt > CW'(1));
    assign w_do        = do_en & ~w_redir;
    assign w_do_cnt    = (do_cnt == '0) ? CW'(1) : do_cnt;
    assign w_set_lovf  = w_do & w_lp_full;

    always_comb begin
        w_faddr_nxt = r_faddr + AW'(1);
        if (jmp | call)
            w_faddr_nxt = jmp_addr;
        else if (ret & ~w_pc_empty)
            w_faddr_nxt = w_pc_top;
        else if (stall)
            w_faddr_nxt = r_faddr;
        else if (w_lp_back)
            w_faddr_nxt = w_lp_start;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_faddr <= RST_VEC;
            r_ptr   <= '0;
            r_povf  <= 1'b0;
            r_pudf  <= 1'b0;
            for (int i = 0; i < PCSTK_DEPTH; i++) r_pcstk[i] <= '0;
        end else begin
            r_faddr <= w_faddr_nxt;
            if (w_push && w_pop) begin
                // Simultaneous push+pop overwrites the top; on an empty stack it is a plain push.
                if (w_pc_empty) begin
                    r_pcstk[0] <= w_pdata;
                    r_ptr      <= PW'(1);
                end else begin
                    r_pcstk[w_top_idx] <= w_pdata;
                end
            end else if (w_push) begin
                if (!w_pc_full) begin
                    r_pcstk[r_ptr[PIW-1:0]] <= w_pdata;
                    r_ptr <= r_ptr + PW'(1);
                end
            end else if (w_pop) begin
                if (!w_pc_empty) r_ptr <= r_ptr - PW'(1);
            end
            r_povf <= w_set_povf | (r_povf & ~clr_stcky);
            r_pudf <= w_set_pudf | (r_pudf & ~clr_stcky);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lptr <= '0;
            r_lovf <= 1'b0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                r_ls_start[i] <= '0;
                r_ls_end[i]   <= '0;
                r_ls_cnt[i]   <= '0;
            end
        end else begin
            if (w_lp_back) r_ls_cnt[w_ltop_idx] <= w_lp_cnt - CW'(1);
            if (w_do && !w_lp_full) begin
                // A loop exiting in the same cycle frees its slot for the new entry.
                if (w_lp_exit) begin
                    r_ls_start[w_ltop_idx] <= do_start;
                    r_ls_end[w_ltop_idx]   <= do_end;
                    r_ls_cnt[w_ltop_idx]   <= w_do_cnt;
                end else begin
                    r_ls_start[r_lptr[LIW-1:0]] <= do_start;
                    r_ls_end[r_lptr[LIW-1:0]]   <= do_end;
                    r_ls_cnt[r_lptr[LIW-1:0]]   <= w_do_cnt;
                    r_lptr <= r_lptr + LW'(1);
                end
            end else if (w_lp_exit) begin
                r_lptr <= r_lptr - LW'(1);
            end
            r_lovf <= w_set_lovf | (r_lovf & ~clr_stcky);
        end
    end

    assign faddr     = r_faddr;
    assign stk_top   = w_pc_top;
    assign stk_ptr   = r_ptr;
    assign stcky     = {r_lovf, r_pudf, r_povf, w_pc_full, w_pc_empty};
    assign lp_active = w_lp_active;
    assign lp_cnt    = w_lp_cnt;
endmodule

// File: doc/ps_fetch_seq.md
Name: ps_fetch_seq

Overview:
- Next-generation program-sequencer fetch core; replaces the fixed 2-entry PC stack with a parametrised PC stack and adds a hardware DO-UNTIL loop stack.
- Generates the program-memory fetch address each cycle from increment, jump, call, return and loop-back sources.
- Keeps sticky stack-status flags.
- Sits between instruction decode (which supplies jump, call, return, push/pop and loop requests) and the PM address port.

Parameters:
AW, 16, address and PC-stack data width
PCSTK_DEPTH, 4, PC stack entries (power of 2, >=2)
LOOP_DEPTH, 2, loop stack entries (>=1)
CW, 16, loop counter width
RST_VEC, 16'h0000, fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
stall  in  1  hold fetch address and loop counters (idle)
jmp  in  1  jump request
jmp_addr  in  AW  jump/call target
call  in  1  call request: jump to jmp_addr and push ret_addr
ret_addr  in  AW  return address pushed by call
ret  in  1  return: fetch from stack top, pop
push  in  1  explicit PC-stack push of push_data
pop  in  1  explicit PC-stack pop
push_data  in  AW  data for explicit push
do_en  in  1  start loop
do_start  in  AW  first address of loop body
do_end  in  AW  last address of loop body
do_cnt  in  CW  iteration count
clr_stcky  in  1  clear overflow/underflow sticky bits
faddr  out  AW  registered fetch address
stk_top  out  AW  PC stack top entry
stk_ptr  out  $clog2(PCSTK_DEPTH)+1  entries in use
stcky  out  5  [0] empty, [1] full, [2] PC ovf, [3] PC udf, [4] loop ovf
lp_active  out  1  loop stack non-empty
lp_cnt  out  CW  remaining count of innermost loop

Behaviour:
- Reset (asynchronous, active-low): faddr=RST_VEC, stk_ptr=0, stcky=5'b00001, lp_active=0, lp_cnt=0, all stack entries 0.
- Next-faddr priority, one registered update per clk:
  - jmp or call -> jmp_addr.
  - else ret and stack non-empty -> stk_top.
  - else stall -> hold.
  - else loop-back condition -> top do_start.
  - else faddr+1, wrapping modulo 2^AW.
- jmp, call and ret take effect even when stall=1.
- If jmp and call are both asserted, the call happens (target jmp_addr, ret_addr pushed); jmp alone never pushes.
- PC stack operations:
  - Effective push = call | (push & !call & !ret & !jmp).
  - Effective pop = (ret & !jmp & !call) | (pop & !call & !ret & !jmp).
  - Explicit push/pop requests coinciding with jmp/call/ret are dropped.
  - Push (call writes ret_addr, push writes push_data): written at index stk_ptr, stk_ptr+1.
  - Push when full: no write, stk_ptr holds, stcky[2] set.
  - Pop: stk_ptr-1. Pop when empty: stk_ptr holds, stcky[3] set.
  - ret when empty: treated as no return, faddr follows the normal rules, stcky[3] set.
  - Explicit push and pop in the same cycle (no jmp/call/ret): replaces the top entry with push_data and stk_ptr is unchanged. If the stack is empty, this acts as a push.
- stk_top: combinational entry[stk_ptr-1]; 16'h0 when empty. Visible the cycle after a push.
- Sticky flags:
  - stcky[0] = (stk_ptr==0) and stcky[1] = (stk_ptr==PCSTK_DEPTH), registered with the pointer.
  - stcky[2], stcky[3] and stcky[4] hold until clr_stcky or reset.
  - Set has priority over clr_stcky in the same cycle.
- Loop stack (entries {start, end, cnt}):
  - do_en pushes {do_start, do_end, max(do_cnt,1)}; do_cnt=0 executes the body once.
  - do_en while the loop stack is full: ignored, stcky[4] set.
  - do_en has effect only when jmp, call and ret are low.
- Loop-back condition: lp_active & !stall & !jmp & !call & !ret & faddr==top.end.
  - If top.cnt>1: faddr<=top.start and top.cnt decrements.
  - If top.cnt==1: faddr<=faddr+1 and the loop stack pops, exposing the outer loop.
  - Nested loops sharing the same end address terminate the inner loop first; the outer loop's check happens on its next pass through that end address.
- lp_cnt = top.cnt, 0 when the loop stack is empty.
- A jmp/call/ret landing on the end address is not evaluated as loop-back in that cycle.
- Reset mid-operation: all state returns to reset values immediately; pending loops are discarded.

Test Plan:
- Reset release, no requests: faddr goes 0,1,2,3 on successive clks; stcky=5'b00001, stk_ptr=0.
- call jmp_addr=16'h0040, ret_addr=16'h0011, then ret two cycles later: faddr goes 16'h0040 then 16'h0041; after ret, faddr=16'h0011, stk_ptr 1->0, stcky[0]=1.
- Five explicit pushes (DEPTH=4) of 16'hA0..A4: stk_ptr=4, stcky[1]=1 after the 4th push, stcky[2]=1 after the 5th, stk_top=16'hA3. Pulse clr_stcky: stcky[2]=0, stcky[1]=1 still.
- pop with the stack empty: stk_ptr=0, stcky[3]=1. Same-cycle push+pop with top=16'hA3: top becomes push_data, stk_ptr unchanged.
- do_en start=16'h10, end=16'h12, cnt=3: faddr sequence 10,11,12,10,11,12,10,11,12,13; lp_cnt 3->2->1, lp_active=0 after the final 12. With stall held at faddr=16'h12, faddr and lp_cnt are frozen.
- Nested loops (outer 16'h20-16'h25 cnt 2, inner 16'h21-16'h22 cnt 2), then a third do_en with LOOP_DEPTH=2: third request ignored and stcky[4]=1; full trace shows 2 inner iterations per outer pass, ending at faddr=16'h26.
